// File: rtl/quadtree_local_ingress_pkg.sv
// Shared router definitions: packet layout, info codes and route decode helper.
package quadtree_local_ingress_pkg;

  localparam int unsigned RouterWidth     = 36;
  localparam int unsigned RouterFifoDepth = 4;

  // Packet field slices: [35:32] info, [31:16] addr, [15:0] data
  localparam int unsigned InfoMsb = 35;
  localparam int unsigned InfoLsb = 32;
  localparam int unsigned AddrMsb = 31;
  localparam int unsigned AddrLsb = 16;
  localparam int unsigned DataMsb = 15;
  localparam int unsigned DataLsb = 0;

  typedef enum logic [3:0] {
    InfoConfig       = 4'h1,
    InfoCalc         = 4'h2,
    InfoFinBroadcast = 4'h3,
    InfoFinComp      = 4'h4
  } router_info_e;

  // Child-quadrant mask for a head packet; zero means the info code is not routable.
  function automatic logic [3:0] decode_target(logic [3:0] info, logic [1:0] quad);
    logic [3:0] mask;
    mask = 4'b0000;
    case (info)
      InfoConfig:                             mask[quad] = 1'b1;
      InfoCalc, InfoFinBroadcast, InfoFinComp: mask = 4'b1111;
      default:                                mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/quadtree_local_ingress_credit_fifo.sv
// Circular FIFO with occupancy count and a registered one-cycle credit pulse per pop.
module quadtree_local_ingress_credit_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 36
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o,
  output logic             credit_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(ptr_t p);
    if (p == ptr_t'(Depth - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             credit_q, credit_d;

  // Next-state for storage, pointers, count and credit pulse
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = pop_i;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards contents without issuing credit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // Status and head outputs; head reads as zero when empty
  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CntW'(Depth));
    head_o   = empty_o ? '0 : mem_q[rd_ptr_q];
    credit_o = credit_q;
  end

endmodule

// File: rtl/quadtree_local_ingress.sv
// LOCAL-port ingress of the root router: buffers controller packets and fans the head
// packet out to one child (CONFIG) or all four (multicast), returning a credit per retire.
module quadtree_local_ingress
  import quadtree_local_ingress_pkg::*;
#(
  parameter int unsigned DEPTH    = RouterFifoDepth,
  parameter int unsigned QUAD_LSB = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_data_valid,
  input  logic [RouterWidth-1:0] in_data,
  output logic                   upstream_credit,
  output logic [3:0]             out_valid,
  output logic [RouterWidth-1:0] out_data,
  input  logic [3:0]             out_ready,
  output logic                   err
);

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [RouterWidth-1:0] head;
  logic                   head_valid;
  logic [15:0]            head_addr;
  logic [3:0]             target;
  logic [3:0]             transfers;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   bad_info;
  logic [3:0]             sent_mask_q, sent_mask_d;
  logic                   err_q, err_d;

  quadtree_local_ingress_credit_fifo #(
    .Depth(DEPTH),
    .Width(RouterWidth)
  ) u_credit_fifo (
    .clk_i    (clk),
    .rst_i    (rst),
    .push_i   (push),
    .wdata_i  (in_data),
    .pop_i    (pop),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .head_o   (head),
    .credit_o (upstream_credit)
  );

  // Route decode, fan-out handshake, retire and error detection
  always_comb begin
    head_valid = !fifo_empty;
    head_addr  = head[AddrMsb:AddrLsb];
    target     = decode_target(head[InfoMsb:InfoLsb], head_addr[QUAD_LSB +: 2]);
    out_valid  = head_valid ? (target & ~sent_mask_q) : 4'b0000;
    out_data   = head;
    transfers  = out_valid & out_ready;
    // An unroutable head has an empty target, so it retires immediately
    pop        = head_valid && ((sent_mask_q | transfers) == target);
    push       = in_data_valid && (!fifo_full || pop);
    drop       = in_data_valid && fifo_full && !pop;
    bad_info   = head_valid && (target == 4'b0000);
    sent_mask_d = pop ? 4'b0000 : (sent_mask_q | transfers);
    err_d       = err_q | drop | bad_info;
    err         = err_q;
  end

  // Per-packet delivery record and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_mask_q <= 4'b0000;
      err_q       <= 1'b0;
    end else begin
      sent_mask_q <= sent_mask_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_quadtree_local_ingress.sv
// Directed bench for quadtree_local_ingress with hand-computed expectations.
module tb_quadtree_local_ingress;

  logic        clk;
  logic        rst;
  logic        in_data_valid;
  logic [35:0] in_data;
  logic        upstream_credit;
  logic [3:0]  out_valid;
  logic [35:0] out_data;
  logic [3:0]  out_ready;
  logic        err;

  int checks;
  int failures;

  quadtree_local_ingress #(
    .DEPTH(4),
    .QUAD_LSB(14)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data_valid   (in_data_valid),
    .in_data         (in_data),
    .upstream_credit (upstream_credit),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] pkt(input logic [3:0] info, input logic [15:0] addr,
                                      input logic [15:0] data);
    return {info, addr, data};
  endfunction

  logic [35:0] q [4];

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    in_data_valid = 1'b0;
    in_data       = '0;
    out_ready     = 4'b0000;
    #2;
    check("reset_out_valid", 36'(out_valid), 36'(4'b0000));
    check("reset_out_data", out_data, 36'h0);
    check("reset_credit", 36'(upstream_credit), 36'(1'b0));
    check("reset_err", 36'(err), 36'(1'b0));
    step();
    rst = 1'b0;
    step();

    // Unicast CONFIG to quadrant 1 with all children ready
    out_ready     = 4'b1111;
    in_data_valid = 1'b1;
    in_data       = pkt(4'h1, 16'h4000, 16'h1234);
    step();
    in_data_valid = 1'b0;
    check("cfg_out_valid", 36'(out_valid), 36'(4'b0010));
    check("cfg_out_data", out_data, 36'h1_4000_1234);
    check("cfg_no_credit_yet", 36'(upstream_credit), 36'(1'b0));
    step();
    check("cfg_credit", 36'(upstream_credit), 36'(1'b1));
    check("cfg_drained", 36'(out_valid), 36'(4'b0000));
    step();
    check("cfg_credit_one_cycle", 36'(upstream_credit), 36'(1'b0));
    check("cfg_err", 36'(err), 36'(1'b0));

    // CALC multicast with children accepting at t, t+2 and t+4
    out_ready     = 4'b0000;
    in_data_valid = 1'b1;
    in_data       = pkt(4'h2, 16'h0000, 16'hbeef);
    step();
    in_data_valid = 1'b0;
    check("calc_valid_all", 36'(out_valid), 36'(4'b1111));
    out_ready = 4'b0001;
    step();
    check("calc_after_c0", 36'(out_valid), 36'(4'b1110));
    out_ready = 4'b0000;
    step();
    check("calc_hold", 36'(out_valid), 36'(4'b1110));
    check("calc_no_early_credit", 36'(upstream_credit), 36'(1'b0));
    out_ready = 4'b1000;
    step();
    check("calc_after_c3", 36'(out_valid), 36'(4'b0110));
    out_ready = 4'b0000;
    step();
    check("calc_hold2", 36'(out_valid), 36'(4'b0110));
    out_ready = 4'b0110;
    step();
    out_ready = 4'b0000;
    check("calc_credit", 36'(upstream_credit), 36'(1'b1));
    check("calc_retired", 36'(out_valid), 36'(4'b0000));
    step();
    check("calc_credit_once", 36'(upstream_credit), 36'(1'b0));

    // Fill all four entries with no child ready
    for (int i = 0; i < 4; i++) q[i] = pkt(4'h1, 16'(i) << 14, 16'ha0 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      in_data_valid = 1'b1;
      in_data       = q[i];
      step();
      check("fill_no_credit", 36'(upstream_credit), 36'(1'b0));
    end
    // Fifth packet while full and no pop: dropped, err raised
    in_data = pkt(4'h1, 16'h0000, 16'hdead);
    step();
    in_data_valid = 1'b0;
    check("full_drop_err", 36'(err), 36'(1'b1));
    check("full_head_intact", out_data, q[0]);
    check("full_head_valid", 36'(out_valid), 36'(4'b0001));
    // Drain: four consecutive pops in FIFO order, four consecutive credit cycles
    out_ready = 4'b1111;
    for (int i = 1; i < 4; i++) begin
      step();
      check("drain_credit", 36'(upstream_credit), 36'(1'b1));
      check("drain_order", out_data, q[i]);
    end
    step();
    check("drain_last_credit", 36'(upstream_credit), 36'(1'b1));
    check("drain_empty", 36'(out_valid), 36'(4'b0000));
    check("drain_empty_data", out_data, 36'h0);
    step();
    check("drain_credit_end", 36'(upstream_credit), 36'(1'b0));

    // Clear sticky err
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("err_cleared", 36'(err), 36'(1'b0));

    // Back-to-back FIN_BROADCAST then FIN_COMP with push and pop in the same cycle
    out_ready     = 4'b1111;
    in_data_valid = 1'b1;
    in_data       = pkt(4'h3, 16'h0000, 16'h0011);
    step();
    in_data       = pkt(4'h4, 16'hc000, 16'h0022);
    check("finb_valid", 36'(out_valid), 36'(4'b1111));
    step();
    in_data_valid = 1'b0;
    check("finc_valid", 36'(out_valid), 36'(4'b1111));
    check("finc_data", out_data, 36'h4_c000_0022);
    check("finb_credit", 36'(upstream_credit), 36'(1'b1));
    step();
    check("finc_credit", 36'(upstream_credit), 36'(1'b1));
    check("b2b_empty", 36'(out_valid), 36'(4'b0000));
    step();

    // Unroutable info code: no requests, immediate pop with credit, err set
    out_ready     = 4'b0000;
    in_data_valid = 1'b1;
    in_data       = pkt(4'hf, 16'h4000, 16'h5555);
    step();
    in_data_valid = 1'b0;
    check("bad_no_valid", 36'(out_valid), 36'(4'b0000));
    check("bad_err_pre", 36'(err), 36'(1'b0));
    step();
    check("bad_credit", 36'(upstream_credit), 36'(1'b1));
    check("bad_err", 36'(err), 36'(1'b1));
    check("bad_popped", out_data, 36'h0);

    // Asynchronous reset in the middle of a multicast
    in_data_valid = 1'b1;
    in_data       = pkt(4'h2, 16'h0000, 16'h7777);
    step();
    in_data_valid = 1'b0;
    out_ready     = 4'b0001;
    step();
    out_ready = 4'b0000;
    check("mid_partial", 36'(out_valid), 36'(4'b1110));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 36'(out_valid), 36'(4'b0000));
    check("arst_data", out_data, 36'h0);
    check("arst_credit", 36'(upstream_credit), 36'(1'b0));
    check("arst_err", 36'(err), 36'(1'b0));
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid", 36'(out_valid), 36'(4'b0000));
    check("post_rst_credit", 36'(upstream_credit), 36'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quadtree_local_ingress.md
# quadtree_local_ingress

Ingress buffer for the LOCAL input port of the root quadtree router, directly downstream of the root controller. It absorbs the controller's 36-bit packets into a credit-managed FIFO. It routes each head packet either to one child quadrant (CONFIG unicast) or to all four (CALC / FIN_BROADCAST / FIN_COMP multicast), and returns one credit per retired packet to the controller's downstream-credit input.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; must equal `ROUTER_FIFO_DEPTH`, the controller's initial credit count.
- QUAD_LSB, 14: LSB of the 2-bit child-select field inside route address in_data[31:16].

Ports:
- clk  in  1  system clock
- rst  in  1  system reset; one clock; reset is asynchronous and active-high
- in_data_valid  in  1  packet from root controller
- in_data  in  36  packet fields: [35:32] info, [31:16] addr, [15:0] data
- upstream_credit  out  1  one-cycle pulse per retired packet; drives the controller's downstream_credit
- out_valid  out  4  per-child request, one bit per quadrant 0..3
- out_data  out  36  head packet, shared by all children
- out_ready  in  4  per-child accept
- err  out  1  sticky protocol-error flag

## Operation
- FIFO: circular buffer of DEPTH x 36 with rd_ptr, wr_ptr and count (width clog2(DEPTH+1)); pointers wrap modulo DEPTH.
- Push: in_data_valid and (count < DEPTH, or a pop in the same cycle).
  - If in_data_valid arrives while full with no same-cycle pop, drop the packet and set err.
- Target mask, decoded from the head:
  - info == `ROUTER_INFO_CONFIG`: one-hot(addr[QUAD_LSB+1:QUAD_LSB]).
  - info == `ROUTER_INFO_CALC`, `ROUTER_INFO_FIN_BROADCAST` or `ROUTER_INFO_FIN_COMP`: 4'b1111.
  - Any other info: 4'b0000. Pop immediately, return credit, set err.
- Per-packet state: a sent_mask register (4 bits).
  - out_valid = target & ~sent_mask when count > 0, else 0.
  - Transfer on child i occurs when out_valid[i] && out_ready[i].
- Retire: when (sent_mask | transfers) == target, pop the head and clear sent_mask.
  - Otherwise sent_mask <= sent_mask | transfers.
- Multicast children may accept in different cycles; a partly-sent packet stays at the head and blocks the FIFO until it is complete.
- out_data = head entry when count > 0, else 0.
- err clears only on rst.

## Timing
- Reset values: count 0, pointers 0, sent_mask 0, upstream_credit 0, err 0, out_valid 0, out_data 0.
- Push at edge N: the packet is visible at the head (out_valid asserted) during cycle N+1 if the FIFO was empty. No combinational path from in_data to out_*.
- Unicast with out_ready already high: pop at the first edge of head visibility. upstream_credit pulses high during the cycle after the pop edge, for exactly one cycle per pop.
- Back-to-back pops give a continuous credit high across consecutive cycles; upstream_credit is never merged or dropped.
- Simultaneous push and pop: count unchanged; both pointers advance.
- DEPTH packets can be in flight with zero stall, given the controller's credit counting.
- Reset mid-multicast: sent_mask and FIFO contents are discarded, and no credit is issued for the lost entries.

## Structure
- Shared package/header (router.vh): `ROUTER_INFO_*` codes, `ROUTER_WIDTH` (36), `ROUTER_FIFO_DEPTH`, and field-slice constants for info/addr/data.
- One natural sub-module, credit_fifo: storage, pointers, count, push/pop, and the registered credit pulse on pop.
- The top level holds the route decode, sent_mask and err.

## Test plan
- Reset, then CONFIG addr 0x4000 data 0x1234 with out_ready=4'b1111 -> out_valid=4'b0010 one cycle after push; upstream_credit pulses 1 cycle later; err 0.
- CALC packet with out_ready staggered (child 0 at t, child 3 at t+2, children 1 and 2 at t+4) -> out_valid goes 1111 -> 1110 -> 0110 -> pop; exactly one credit pulse after the t+4 edge.
- out_ready=0; push 4 CONFIG packets -> count 4, no credits; raise out_ready=1111 -> 4 consecutive pops and 4 consecutive credit cycles, delivered in FIFO order.
- Push a 5th packet while full with no pop -> packet dropped, err=1, count stays 4, contents intact.
- Head with info code 4'hF -> no out_valid, pop, credit pulse, err=1. Then assert rst mid-multicast -> all outputs return to 0 asynchronously.
